// File: rtl/dl_pkg.sv
// Shared Data Link layer definitions.
//   ACK / NAK      : encodings of the dllp_type field
//   SEQ_W          : default sequence-number width (sequence space is modulo 2^SEQ_W)
//   REPLAY_NUM_W   : width of the REPLAY_NUM counter
//   seq_diff()     : modulo subtraction of sequence numbers of a given width
package dl_pkg;

    localparam int   SEQ_W        = 12;
    localparam int   REPLAY_NUM_W = 2;
    localparam logic ACK          = 1'b0;
    localparam logic NAK          = 1'b1;

    // (a - b) mod 2^width. Operands are zero-extended to 32 bits by the caller,
    // so one helper serves any sequence width up to 31 bits.
    function automatic logic [31:0] seq_diff(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          width
    );
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/dl_replay_timer.sv
// Replay timer for the Ack/Nak handler.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin timing (count = 0, running = 1) if not already running
//   clear       : count = 0, running = restart_if (highest priority after reset)
//   hold        : keep count at 0 (replay buffer busy), running unchanged
//   restart_if  : running value loaded by clear
//   expire      : count has reached replay_timer_limit-1 while running
//   running     : timer active (registered)
module dl_replay_timer #(
    parameter int timer_width        = 16,
    parameter int replay_timer_limit = 711
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    input  logic hold,
    input  logic restart_if,
    output logic expire,
    output logic running
);

    localparam logic [timer_width-1:0] LIMIT_M1 = timer_width'(replay_timer_limit - 1);
    localparam logic [timer_width-1:0] CNT_ZERO = {timer_width{1'b0}};
    localparam logic [timer_width-1:0] CNT_ONE  = timer_width'(1);

    logic [timer_width-1:0] count_r;
    logic [timer_width-1:0] count_next_s;
    logic                   running_r;
    logic                   running_next_s;

    // Expiry can only occur with rb_busy low: hold pins the count at zero.
    assign expire  = running_r && (count_r == LIMIT_M1);
    assign running = running_r;

    // Next-state selection: clear > hold > expire > start > count.
    always_comb begin
        count_next_s   = count_r;
        running_next_s = running_r;
        if (clear) begin
            count_next_s   = CNT_ZERO;
            running_next_s = restart_if;
        end else if (hold) begin
            count_next_s   = CNT_ZERO;
            running_next_s = running_r;
        end else if (expire) begin
            count_next_s   = CNT_ZERO;
            running_next_s = 1'b0;
        end else if (start && !running_r) begin
            count_next_s   = CNT_ZERO;
            running_next_s = 1'b1;
        end else if (running_r) begin
            count_next_s   = count_r + CNT_ONE;
            running_next_s = 1'b1;
        end else begin
            count_next_s   = count_r;
            running_next_s = running_r;
        end
    end

    // Timer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r   <= CNT_ZERO;
            running_r <= 1'b0;
        end else begin
            count_r   <= count_next_s;
            running_r <= running_next_s;
        end
    end

endmodule

// File: rtl/dl_ack_nak_handler.sv
// Data Link TX-side Ack/Nak handler, sitting directly upstream of the replay buffer.
// Validates incoming Ack/Nak sequence numbers against ACKD_SEQ and NEXT_TRANSMIT_SEQ,
// commands the replay buffer (purge / replay / timeout), owns the replay timer and
// the REPLAY_NUM counter, and requests retrain when REPLAY_NUM rolls over.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   dllp_valid/type/seq  : decoded, CRC-checked Ack (0) / Nak (1) DLLP strobe
//   next_tx_seq          : NEXT_TRANSMIT_SEQ from the replay buffer
//   tlp_tx_done          : a new TLP was stored and sent
//   rb_busy              : replay buffer is replaying or purging
//   ack_nak_seq_num      : sequence number of the last accepted Ack/Nak
//   ack_forward_progress : purge pulse
//   nak_forward_progress : purge-then-replay pulse
//   time_out             : replay-all pulse on timer expiry
//   acked_seq            : ACKD_SEQ
//   replay_num           : REPLAY_NUM
//   retrain_req          : REPLAY_NUM rolled over 3 -> 0
//   dllp_protocol_error  : out-of-range Ack/Nak sequence number
//   timer_running        : replay timer active
// All outputs are registered: responses appear one cycle after the causing edge.
module dl_ack_nak_handler
    import dl_pkg::*;
#(
    parameter int seq_num_width      = SEQ_W,
    parameter int timer_width        = 16,
    parameter int replay_timer_limit = 711
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dllp_valid,
    input  logic                     dllp_type,
    input  logic [seq_num_width-1:0] dllp_seq,
    input  logic [seq_num_width-1:0] next_tx_seq,
    input  logic                     tlp_tx_done,
    input  logic                     rb_busy,
    output logic [seq_num_width-1:0] ack_nak_seq_num,
    output logic                     ack_forward_progress,
    output logic                     nak_forward_progress,
    output logic                     time_out,
    output logic [seq_num_width-1:0] acked_seq,
    output logic [REPLAY_NUM_W-1:0]  replay_num,
    output logic                     retrain_req,
    output logic                     dllp_protocol_error,
    output logic                     timer_running
);

    localparam logic [seq_num_width-1:0] SEQ_ZERO = {seq_num_width{1'b0}};
    localparam logic [seq_num_width-1:0] SEQ_ONE  = seq_num_width'(1);
    localparam logic [seq_num_width-1:0] SEQ_ONES = {seq_num_width{1'b1}};
    localparam logic [seq_num_width-1:0] HALF     = {1'b1, {(seq_num_width-1){1'b0}}};
    localparam logic [REPLAY_NUM_W-1:0]  RN_ZERO  = {REPLAY_NUM_W{1'b0}};
    localparam logic [REPLAY_NUM_W-1:0]  RN_ONE   = REPLAY_NUM_W'(1);
    localparam logic [REPLAY_NUM_W-1:0]  RN_MAX   = {REPLAY_NUM_W{1'b1}};

    // Modulo subtraction in this instance's sequence width.
    function automatic logic [seq_num_width-1:0] sub_mod(
        input logic [seq_num_width-1:0] a,
        input logic [seq_num_width-1:0] b
    );
        return seq_num_width'(seq_diff(32'(a), 32'(b), seq_num_width));
    endfunction

    // Registered state and outputs
    logic [seq_num_width-1:0] acked_seq_r;
    logic [seq_num_width-1:0] ack_nak_seq_num_r;
    logic [REPLAY_NUM_W-1:0]  replay_num_r;
    logic                     ack_fp_r;
    logic                     nak_fp_r;
    logic                     time_out_r;
    logic                     retrain_r;
    logic                     proto_err_r;
    logic                     rb_busy_d_r;

    // Combinational decisions
    logic [seq_num_width-1:0] lastsent_s;
    logic [seq_num_width-1:0] dist_hi_s;
    logic [seq_num_width-1:0] dist_lo_s;
    logic                     in_range_s;
    logic                     progress_s;
    logic                     ack_accept_s;
    logic                     nak_accept_s;
    logic                     proto_err_s;
    logic [seq_num_width-1:0] acked_next_s;
    logic [seq_num_width-1:0] ack_nak_next_s;
    logic                     outstanding_s;
    logic                     rb_fall_s;
    logic                     timer_clear_s;
    logic                     timer_restart_s;
    logic                     timer_start_s;
    logic                     timer_expire_s;
    logic                     timer_running_s;
    logic                     time_out_s;
    logic [REPLAY_NUM_W-1:0]  replay_num_next_s;
    logic                     retrain_s;

    // Classify the incoming DLLP: accepted Ack, accepted Nak, or out of range.
    always_comb begin
        lastsent_s   = sub_mod(next_tx_seq, SEQ_ONE);
        dist_hi_s    = sub_mod(lastsent_s, dllp_seq);
        dist_lo_s    = sub_mod(dllp_seq, acked_seq_r);
        in_range_s   = (dist_hi_s < HALF) && (dist_lo_s < HALF);
        progress_s   = (dllp_seq != acked_seq_r);
        ack_accept_s = 1'b0;
        nak_accept_s = 1'b0;
        proto_err_s  = 1'b0;
        if (dllp_valid) begin
            if (!in_range_s) begin
                proto_err_s = 1'b1;
            end else if ((dllp_type == NAK) && !rb_busy) begin
                nak_accept_s = 1'b1;
            end else if (progress_s) begin
                // Ack, or a Nak arriving mid-replay: purge only, never a second replay.
                ack_accept_s = 1'b1;
            end else begin
                ack_accept_s = 1'b0;
            end
        end else begin
            proto_err_s = 1'b0;
        end
    end

    // Next ACKD_SEQ, timer commands and REPLAY_NUM update.
    always_comb begin
        acked_next_s   = acked_seq_r;
        ack_nak_next_s = ack_nak_seq_num_r;
        if (ack_accept_s || nak_accept_s) begin
            acked_next_s   = dllp_seq;
            ack_nak_next_s = dllp_seq;
        end else begin
            acked_next_s   = acked_seq_r;
            ack_nak_next_s = ack_nak_seq_num_r;
        end

        // Outstanding is judged against the post-update ACKD_SEQ; next_tx_seq
        // already reflects any TLP completing this cycle.
        outstanding_s   = (lastsent_s != acked_next_s);
        rb_fall_s       = rb_busy_d_r && !rb_busy;
        timer_clear_s   = ack_accept_s || nak_accept_s || rb_fall_s;
        timer_restart_s = outstanding_s && !nak_accept_s;
        timer_start_s   = tlp_tx_done && !rb_busy;

        // An accepted Ack or Nak in the expiry cycle takes precedence over time_out.
        time_out_s = timer_expire_s && !ack_accept_s && !nak_accept_s;

        replay_num_next_s = replay_num_r;
        retrain_s         = 1'b0;
        if (ack_accept_s) begin
            replay_num_next_s = RN_ZERO;
        end else if (nak_accept_s && progress_s) begin
            replay_num_next_s = RN_ONE;
        end else if (nak_accept_s || time_out_s) begin
            replay_num_next_s = replay_num_r + RN_ONE;
            retrain_s         = (replay_num_r == RN_MAX);
        end else begin
            replay_num_next_s = replay_num_r;
        end
    end

    dl_replay_timer #(
        .timer_width        (timer_width),
        .replay_timer_limit (replay_timer_limit)
    ) u_replay_timer (
        .clk        (clk),
        .rst        (rst),
        .start      (timer_start_s),
        .clear      (timer_clear_s),
        .hold       (rb_busy),
        .restart_if (timer_restart_s),
        .expire     (timer_expire_s),
        .running    (timer_running_s)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acked_seq_r       <= SEQ_ONES;
            ack_nak_seq_num_r <= SEQ_ZERO;
            replay_num_r      <= RN_ZERO;
            ack_fp_r          <= 1'b0;
            nak_fp_r          <= 1'b0;
            time_out_r        <= 1'b0;
            retrain_r         <= 1'b0;
            proto_err_r       <= 1'b0;
            rb_busy_d_r       <= 1'b0;
        end else begin
            acked_seq_r       <= acked_next_s;
            ack_nak_seq_num_r <= ack_nak_next_s;
            replay_num_r      <= replay_num_next_s;
            ack_fp_r          <= ack_accept_s;
            nak_fp_r          <= nak_accept_s;
            time_out_r        <= time_out_s;
            retrain_r         <= retrain_s;
            proto_err_r       <= proto_err_s;
            rb_busy_d_r       <= rb_busy;
        end
    end

    assign ack_nak_seq_num      = ack_nak_seq_num_r;
    assign ack_forward_progress = ack_fp_r;
    assign nak_forward_progress = nak_fp_r;
    assign time_out             = time_out_r;
    assign acked_seq            = acked_seq_r;
    assign replay_num           = replay_num_r;
    assign retrain_req          = retrain_r;
    assign dllp_protocol_error  = proto_err_r;
    assign timer_running        = timer_running_s;

endmodule

// File: tb/tb_dl_ack_nak_handler.sv
// Directed testbench for dl_ack_nak_handler (replay_timer_limit = 20).
module tb_dl_ack_nak_handler;
    import dl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dllp_valid;
    logic        dllp_type;
    logic [11:0] dllp_seq;
    logic [11:0] next_tx_seq;
    logic        tlp_tx_done;
    logic        rb_busy;
    logic [11:0] ack_nak_seq_num;
    logic        ack_forward_progress;
    logic        nak_forward_progress;
    logic        time_out;
    logic [11:0] acked_seq;
    logic [1:0]  replay_num;
    logic        retrain_req;
    logic        dllp_protocol_error;
    logic        timer_running;
    logic [4:0]  pulses;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    assign pulses = {ack_forward_progress, nak_forward_progress, time_out,
                     retrain_req, dllp_protocol_error};

    dl_ack_nak_handler #(
        .seq_num_width      (12),
        .timer_width        (16),
        .replay_timer_limit (20)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .dllp_valid           (dllp_valid),
        .dllp_type            (dllp_type),
        .dllp_seq             (dllp_seq),
        .next_tx_seq          (next_tx_seq),
        .tlp_tx_done          (tlp_tx_done),
        .rb_busy              (rb_busy),
        .ack_nak_seq_num      (ack_nak_seq_num),
        .ack_forward_progress (ack_forward_progress),
        .nak_forward_progress (nak_forward_progress),
        .time_out             (time_out),
        .acked_seq            (acked_seq),
        .replay_num           (replay_num),
        .retrain_req          (retrain_req),
        .dllp_protocol_error  (dllp_protocol_error),
        .timer_running        (timer_running)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        next_tx_seq = 12'd0;
        rb_busy     = 1'b0;
        dllp_valid  = 1'b0;
        tlp_tx_done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_tlp(input logic [11:0] seq);
        next_tx_seq = seq + 12'd1;
        tlp_tx_done = 1'b1;
        tick();
        tlp_tx_done = 1'b0;
    endtask

    task automatic send_dllp(input logic t, input logic [11:0] s);
        dllp_valid = 1'b1;
        dllp_type  = t;
        dllp_seq   = s;
        tick();
        dllp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dllp_valid = 1'b0; dllp_type = 1'b0; dllp_seq = 12'd0;
        next_tx_seq = 12'd0; tlp_tx_done = 1'b0; rb_busy = 1'b0;

        // ---- Reset values, then Ack progress / timer stop
        do_reset();
        check("rst_acked", acked_seq, 32'd4095);
        check("rst_ans", ack_nak_seq_num, 32'd0);
        check("rst_rnum", replay_num, 32'd0);
        check("rst_run", timer_running, 32'd0);
        check("rst_pulses", pulses, 32'd0);
        for (int s = 0; s < 5; s++) send_tlp(12'(s));
        check("s1_run_started", timer_running, 32'd1);
        send_dllp(ACK, 12'd2);
        check("s1_ack2_pulses", pulses, 32'b10000);
        check("s1_ack2_ans", ack_nak_seq_num, 32'd2);
        check("s1_ack2_acked", acked_seq, 32'd2);
        check("s1_ack2_run", timer_running, 32'd1);
        tick();
        check("s1_pulse_drop", pulses, 32'd0);
        send_dllp(ACK, 12'd4);
        check("s1_ack4_acked", acked_seq, 32'd4);
        check("s1_ack4_run", timer_running, 32'd0);

        // ---- Timer expiry 20 cycles after the first tlp_tx_done, four times
        do_reset();
        send_tlp(12'd0);
        send_tlp(12'd1);
        send_tlp(12'd2);
        repeat (17) tick();
        check("s2_to_early", time_out, 32'd0);
        tick();
        check("s2_to_1", time_out, 32'd1);
        check("s2_rnum_1", replay_num, 32'd1);
        check("s2_run_off", timer_running, 32'd0);
        for (int r = 2; r <= 4; r++) begin
            send_tlp(12'(r + 1));
            repeat (19) tick();
            check("s2_to_early_r", time_out, 32'd0);
            tick();
            check("s2_to_r", time_out, 32'd1);
            check("s2_rnum_r", replay_num, 32'(r % 4));
            check("s2_retrain_r", retrain_req, 32'(r == 4));
        end
        tick();
        check("s2_retrain_drop", pulses, 32'd0);

        // ---- Nak with progress, then repeated Nak after replay finishes
        do_reset();
        for (int s = 0; s < 9; s++) send_tlp(12'(s));
        send_dllp(ACK, 12'd5);
        check("s3_ack5_acked", acked_seq, 32'd5);
        send_dllp(NAK, 12'd7);
        check("s3_nak7_pulses", pulses, 32'b01000);
        check("s3_nak7_acked", acked_seq, 32'd7);
        check("s3_nak7_ans", ack_nak_seq_num, 32'd7);
        check("s3_nak7_rnum", replay_num, 32'd1);
        check("s3_nak7_run", timer_running, 32'd0);
        rb_busy = 1'b1;
        repeat (3) tick();
        rb_busy = 1'b0;
        tick();
        check("s3_restart_run", timer_running, 32'd1);
        send_dllp(NAK, 12'd7);
        check("s3_nak7b_pulses", pulses, 32'b01000);
        check("s3_nak7b_rnum", replay_num, 32'd2);
        check("s3_nak7b_acked", acked_seq, 32'd7);

        // ---- Sequence wrap-around and out-of-range Ack
        do_reset();
        next_tx_seq = 12'd2001;
        send_dllp(ACK, 12'd2000);
        check("s4_acked_2000", acked_seq, 32'd2000);
        next_tx_seq = 12'd4001;
        send_dllp(ACK, 12'd4000);
        next_tx_seq = 12'd3;
        send_dllp(ACK, 12'd4094);
        check("s4_acked_4094", acked_seq, 32'd4094);
        send_dllp(ACK, 12'd1);
        check("s4_wrap_pulses", pulses, 32'b10000);
        check("s4_wrap_acked", acked_seq, 32'd1);
        send_dllp(ACK, 12'd2100);
        check("s4_err_pulses", pulses, 32'b00001);
        check("s4_err_acked", acked_seq, 32'd1);
        check("s4_err_ans", ack_nak_seq_num, 32'd1);

        // ---- Ack in the same cycle the timer reaches limit-1
        do_reset();
        for (int s = 0; s < 4; s++) send_tlp(12'(s));
        repeat (16) tick();
        send_dllp(ACK, 12'd1);
        check("s5_ack_vs_exp_pulses", pulses, 32'b10000);
        check("s5_rnum", replay_num, 32'd0);
        check("s5_run", timer_running, 32'd1);
        tick();
        check("s5_no_late_to", time_out, 32'd0);

        // ---- Nak while replaying acts as Ack; reset mid-replay
        rb_busy = 1'b1;
        send_dllp(NAK, 12'd2);
        check("s6_busy_nak_pulses", pulses, 32'b10000);
        check("s6_busy_nak_acked", acked_seq, 32'd2);
        rb_busy = 1'b0;
        tick();
        send_dllp(NAK, 12'd2);
        check("s6_nak_rnum", replay_num, 32'd1);
        rb_busy = 1'b1;
        repeat (2) tick();
        rst        = 1'b1;
        dllp_valid = 1'b1;
        dllp_type  = NAK;
        dllp_seq   = 12'd3;
        tick();
        check("s6_rst_acked", acked_seq, 32'd4095);
        check("s6_rst_ans", ack_nak_seq_num, 32'd0);
        check("s6_rst_rnum", replay_num, 32'd0);
        check("s6_rst_run", timer_running, 32'd0);
        check("s6_rst_pulses", pulses, 32'd0);
        rst        = 1'b0;
        dllp_valid = 1'b0;
        rb_busy    = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
